// File: rtl/scope_wave_render_if.sv
// Pixel/ADC bus between the scope renderer and its neighbours: ADC capture
// inputs, TFT driver raster inputs, and the pixel/status outputs.
interface scope_wave_render_if;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic [7:0]  trig_level;
    logic        run;
    logic        force_trig;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        tft_req;
    logic        tft_vs;
    logic [15:0] data_in;
    logic [1:0]  trig_state;
    logic        frame_swap;

    modport master (
        output adc_data, adc_valid, trig_level, run, force_trig,
        output hcount, vcount, tft_req, tft_vs,
        input  data_in, trig_state, frame_swap
    );

    modport slave (
        input  adc_data, adc_valid, trig_level, run, force_trig,
        input  hcount, vcount, tft_req, tft_vs,
        output data_in, trig_state, frame_swap
    );
endinterface

// File: rtl/scope_wave_render.sv
// Triggered 800-sample capture into a double-buffered LUT RAM plus a trace renderer
// for the TFT driver. Define SCOPE_GRID_EN to overlay a 16x10 graticule.
module scope_wave_render #(
    parameter int unsigned H_DISP      = 800,
    parameter logic [10:0] Y_BASE      = 11'd367,
    parameter logic [15:0] TRACE_COLOR = 16'hFFE0,
    parameter logic [15:0] BG_COLOR    = 16'h0000
`ifdef SCOPE_GRID_EN
    ,
    parameter logic [15:0] GRID_COLOR  = 16'h4208
`endif
) (
    input  logic               clk_vga,
    input  logic               rst_n,
    scope_wave_render_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  prev_q, prev_d;
    logic        cap_bank_q, cap_bank_d;
    logic        disp_bank_q, disp_bank_d;
    logic        disp_valid_q, disp_valid_d;
    logic        frame_swap_q, frame_swap_d;
    logic        vs_q;
    logic        vs_edge_q;
    logic [10:0] y_prev_q;

    logic [7:0]  mem_q [0:1][0:H_DISP-1];

    logic        we_s;
    logic [9:0]  waddr_s;
    logic        level_trig_s;
    logic [9:0]  rd_idx_s;
    logic [7:0]  cur_s;
    logic [10:0] y_cur_s;
    logic [10:0] y_ref_s;
    logic [10:0] y_lo_s;
    logic [10:0] y_hi_s;
    logic        hit_s;
    logic [15:0] pix_s;

    assign level_trig_s = bus.adc_valid && (prev_q < bus.trig_level) &&
                          (bus.adc_data >= bus.trig_level);

    // Capture FSM next state; run=0 in ARMED takes priority over a trigger.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        prev_d       = 8'hFF;
        cap_bank_d   = cap_bank_q;
        disp_bank_d  = disp_bank_q;
        disp_valid_d = disp_valid_q;
        frame_swap_d = 1'b0;
        we_s         = 1'b0;
        waddr_s      = wr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (level_trig_s) begin
                    we_s      = 1'b1;
                    waddr_s   = 10'd0;
                    wr_addr_d = 10'd1;
                    state_d   = ST_FILL;
                end else if (bus.force_trig) begin
                    wr_addr_d = 10'd0;
                    state_d   = ST_FILL;
                end else if (bus.adc_valid) begin
                    prev_d = bus.adc_data;
                end else begin
                    prev_d = prev_q;
                end
            end
            ST_FILL: begin
                if (bus.adc_valid) begin
                    we_s = 1'b1;
                    if (wr_addr_q == 10'(H_DISP - 1)) begin
                        wr_addr_d = 10'd0;
                        state_d   = ST_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + 10'd1;
                    end
                end else begin
                    wr_addr_d = wr_addr_q;
                end
            end
            ST_DONE: begin
                if (vs_edge_q) begin
                    cap_bank_d   = disp_bank_q;
                    disp_bank_d  = cap_bank_q;
                    disp_valid_d = 1'b1;
                    frame_swap_d = 1'b1;
                    state_d      = bus.run ? ST_ARMED : ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, bank pointers, vsync edge pipeline and previous-column row.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= 10'd0;
            prev_q       <= 8'hFF;
            cap_bank_q   <= 1'b0;
            disp_bank_q  <= 1'b1;
            disp_valid_q <= 1'b0;
            frame_swap_q <= 1'b0;
            vs_q         <= 1'b1;
            vs_edge_q    <= 1'b0;
            y_prev_q     <= Y_BASE;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            prev_q       <= prev_d;
            cap_bank_q   <= cap_bank_d;
            disp_bank_q  <= disp_bank_d;
            disp_valid_q <= disp_valid_d;
            frame_swap_q <= frame_swap_d;
            vs_q         <= bus.tft_vs;
            vs_edge_q    <= vs_q & ~bus.tft_vs;
            if (bus.tft_req) begin
                y_prev_q <= y_cur_s;
            end else begin
                y_prev_q <= y_prev_q;
            end
        end
    end

    // Sample memory: synchronous write into the capture bank only.
    always_ff @(posedge clk_vga) begin
        if (we_s) begin
            mem_q[cap_bank_q][waddr_s] <= bus.adc_data;
        end
    end

    assign rd_idx_s = (bus.hcount < 11'(H_DISP)) ? bus.hcount[9:0] : 10'd0;
    assign cur_s    = mem_q[disp_bank_q][rd_idx_s];
    assign y_cur_s  = Y_BASE - {3'b000, cur_s};
    assign y_ref_s  = (bus.hcount == 11'd0) ? y_cur_s : y_prev_q;
    assign y_lo_s   = (y_ref_s < y_cur_s) ? y_ref_s : y_cur_s;
    assign y_hi_s   = (y_ref_s < y_cur_s) ? y_cur_s : y_ref_s;
    assign hit_s    = bus.tft_req && disp_valid_q &&
                      (bus.vcount >= y_lo_s) && (bus.vcount <= y_hi_s);

    // Pixel priority: trace over graticule over background.
    always_comb begin
        pix_s = BG_COLOR;
        if (!bus.tft_req) begin
            pix_s = BG_COLOR;
        end else if (hit_s) begin
            pix_s = TRACE_COLOR;
`ifdef SCOPE_GRID_EN
        end else if (((bus.hcount % 11'd50) == 11'd0) ||
                     ((bus.vcount % 11'd48) == 11'd0)) begin
            pix_s = GRID_COLOR;
`endif
        end else begin
            pix_s = BG_COLOR;
        end
    end

    assign bus.data_in    = pix_s;
    assign bus.trig_state = state_q;
    assign bus.frame_swap = frame_swap_q;

endmodule

// File: tb/tb_scope_wave_render.sv
// Directed bench for scope_wave_render: capture scenarios with a sample-level
// model of the displayed trace, checked every cycle by one compare process.
module tb_scope_wave_render;

    localparam logic [15:0] BG    = 16'h0000;
    localparam logic [15:0] TRACE = 16'hFFE0;
`ifdef SCOPE_GRID_EN
    localparam logic [15:0] GRID  = 16'h4208;
`endif

    logic clk_vga = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_vga = ~clk_vga;

    scope_wave_render_if bus_if ();

    scope_wave_render dut (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .bus     (bus_if)
    );

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    logic [7:0] cap_exp  [800];
    logic [7:0] disp_exp [800];
    bit   disp_valid_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected pixel from the displayed samples: column h joins its row to column h-1's row.
    function automatic logic [15:0] model_pix(input int h, input int v, input bit req);
        int yc, yp, lo, hi;
        if (!req) return BG;
        if (disp_valid_exp && h < 800) begin
            yc = 367 - int'(disp_exp[h]);
            yp = (h == 0) ? yc : 367 - int'(disp_exp[h-1]);
            lo = (yc < yp) ? yc : yp;
            hi = (yc < yp) ? yp : yc;
            if (v >= lo && v <= hi) return TRACE;
        end
`ifdef SCOPE_GRID_EN
        if (h % 50 == 0 || v % 48 == 0) return GRID;
`endif
        return BG;
    endfunction

    always @(negedge clk_vga) begin
        if (cmp_en) begin
            chk("pixel", bus_if.data_in,
                model_pix(int'(bus_if.hcount), int'(bus_if.vcount), bus_if.tft_req));
        end
    end

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        bus_if.adc_data  = d;
        bus_if.adc_valid = 1'b1;
        tick();
        bus_if.adc_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int n = 0;
        while (bus_if.trig_state !== s && n < 50) begin
            tick();
            n++;
        end
        chk(name, bus_if.trig_state, s);
    endtask

    task automatic pulse_force();
        bus_if.force_trig = 1'b1;
        tick();
        bus_if.force_trig = 1'b0;
    endtask

    task automatic do_swap(input logic [1:0] state_after);
        chk("done_before_swap", bus_if.trig_state, 2'd3);
        bus_if.tft_vs = 1'b0;
        tick();
        chk("swap_not_yet", bus_if.frame_swap, 1'b0);
        tick();
        chk("swap_pulse", bus_if.frame_swap, 1'b1);
        chk("state_after_swap", bus_if.trig_state, state_after);
        disp_exp       = cap_exp;
        disp_valid_exp = 1'b1;
        tick();
        chk("swap_one_cycle", bus_if.frame_swap, 1'b0);
        bus_if.tft_vs = 1'b1;
        tick();
    endtask

    task automatic sweep(input int v, input int hmax);
        for (int h = 0; h <= hmax; h++) begin
            bus_if.hcount  = 11'(h);
            bus_if.vcount  = 11'(v);
            bus_if.tft_req = 1'b1;
            tick();
        end
        bus_if.tft_req = 1'b0;
        bus_if.hcount  = 11'd0;
    endtask

    task automatic probe(input int v, input int h, input logic [15:0] e, input string name);
        for (int c = 0; c < h; c++) begin
            bus_if.hcount  = 11'(c);
            bus_if.vcount  = 11'(v);
            bus_if.tft_req = 1'b1;
            tick();
        end
        bus_if.hcount  = 11'(h);
        bus_if.vcount  = 11'(v);
        bus_if.tft_req = 1'b1;
        #1;
        chk(name, bus_if.data_in, e);
        tick();
        bus_if.tft_req = 1'b0;
        bus_if.hcount  = 11'd0;
    endtask

    initial begin
        bus_if.adc_data   = 8'h00;
        bus_if.adc_valid  = 1'b0;
        bus_if.trig_level = 8'd128;
        bus_if.run        = 1'b0;
        bus_if.force_trig = 1'b0;
        bus_if.hcount     = 11'd0;
        bus_if.vcount     = 11'd0;
        bus_if.tft_req    = 1'b0;
        bus_if.tft_vs     = 1'b1;
        cmp_en            = 1'b1;
        repeat (3) tick();
        chk("reset_state", bus_if.trig_state, 2'd0);
        chk("reset_swap", bus_if.frame_swap, 1'b0);
        chk("reset_pixel", bus_if.data_in, BG);
        rst_n = 1'b1;
        tick();
        chk("idle_without_run", bus_if.trig_state, 2'd0);
        probe(100, 7, BG, "bg_before_capture");
        sweep(100, 30);

        // Ramp 0..255 with level 128: trigger on sample 128, stored at address 0.
        bus_if.run = 1'b1;
        wait_state(2'd1, "armed_after_run");
        for (int i = 0; i < 128; i++) feed(8'(i));
        chk("armed_below_level", bus_if.trig_state, 2'd1);
        feed(8'd128);
        cap_exp[0] = 8'd128;
        chk("fill_on_128", bus_if.trig_state, 2'd2);
        for (int k = 1; k < 799; k++) begin
            cap_exp[k] = 8'((128 + k) % 256);
            feed(cap_exp[k]);
        end
        chk("fill_before_last", bus_if.trig_state, 2'd2);
        cap_exp[799] = 8'((128 + 799) % 256);
        feed(cap_exp[799]);
        chk("done_after_800", bus_if.trig_state, 2'd3);
        repeat (3) feed(8'h00);
        chk("done_ignores_valid", bus_if.trig_state, 2'd3);
        do_swap(2'd1);
        probe(239, 0, TRACE, "ramp_col0_row239");
        sweep(239, 60);
        sweep(200, 60);

        // Constant 0x80: only row 239 is traced.
        bus_if.trig_level = 8'h80;
        repeat (3) feed(8'h10);
        for (int k = 0; k < 800; k++) begin
            cap_exp[k] = 8'h80;
            feed(8'h80);
        end
        chk("const_done", bus_if.trig_state, 2'd3);
        do_swap(2'd1);
        probe(239, 5, TRACE, "const_row239");
        probe(238, 5, BG, "const_row238");
        probe(241, 5, BG, "const_row241");
        sweep(239, 100);
        sweep(240, 100);

        // Alternating 255/0: column 1 spans rows 112..367.
        bus_if.trig_level = 8'd128;
        feed(8'd0);
        for (int k = 0; k < 800; k++) begin
            cap_exp[k] = (k % 2 == 0) ? 8'd255 : 8'd0;
            feed(cap_exp[k]);
        end
        chk("alt_done", bus_if.trig_state, 2'd3);
        do_swap(2'd1);
        probe(112, 1, TRACE, "alt_row112");
        probe(367, 1, TRACE, "alt_row367");
        probe(200, 1, TRACE, "alt_row200");
        probe(111, 1, BG, "alt_row111");
        probe(368, 1, BG, "alt_row368");
        sweep(111, 20);
        sweep(300, 20);

        // Forced trigger on a flat signal starts at address 0.
        bus_if.trig_level = 8'h80;
        repeat (5) feed(8'h10);
        chk("flat_stays_armed", bus_if.trig_state, 2'd1);
        pulse_force();
        chk("force_fill", bus_if.trig_state, 2'd2);
        for (int k = 0; k < 799; k++) begin
            cap_exp[k] = 8'h10;
            feed(8'h10);
        end
        chk("force_fill_799", bus_if.trig_state, 2'd2);
        cap_exp[799] = 8'h10;
        feed(8'h10);
        chk("force_done_800", bus_if.trig_state, 2'd3);
        do_swap(2'd1);
        probe(351, 3, TRACE, "force_row351");

        // Reset halfway through a fill discards everything on screen.
        pulse_force();
        repeat (400) feed(8'h55);
        chk("midfill_state", bus_if.trig_state, 2'd2);
        bus_if.run     = 1'b0;
        rst_n          = 1'b0;
        disp_valid_exp = 1'b0;
        #1;
        chk("rst_async_state", bus_if.trig_state, 2'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_idle", bus_if.trig_state, 2'd0);
        probe(351, 3, BG, "rst_pixel_bg");
        sweep(351, 50);
        sweep(239, 50);
        bus_if.run = 1'b1;
        wait_state(2'd1, "rearmed");
        pulse_force();
        for (int k = 0; k < 800; k++) begin
            cap_exp[k] = 8'(k % 200);
            feed(cap_exp[k]);
        end
        do_swap(2'd1);
        sweep(300, 100);
        sweep(250, 100);

        // run=0 during FILL: capture completes, then IDLE ignores crossings.
        pulse_force();
        for (int k = 0; k < 10; k++) begin
            cap_exp[k] = 8'hC0;
            feed(8'hC0);
        end
        bus_if.run = 1'b0;
        for (int k = 10; k < 800; k++) begin
            cap_exp[k] = 8'hC0;
            feed(8'hC0);
        end
        chk("run0_done", bus_if.trig_state, 2'd3);
        do_swap(2'd0);
        feed(8'h10);
        feed(8'h90);
        feed(8'h10);
        feed(8'h90);
        pulse_force();
        chk("idle_ignores_trig", bus_if.trig_state, 2'd0);
        probe(175, 4, TRACE, "run0_row175");
        sweep(175, 40);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scope_wave_render.md
# scope_wave_render

Oscilloscope trace renderer and acquisition buffer, sitting directly upstream of the TFT timing driver. It captures triggered 8-bit ADC samples into a double-buffered 800-entry sample memory. It also returns the RGB565 pixel for the driver's current `hcount`/`vcount`, and drives the driver's `data_in`. Bank swaps happen only at a frame boundary, so a frame never shows two captures.

## Interface
- `H_DISP`, 800: samples per capture, equal to the visible width.
- `Y_BASE`, 367: screen row for sample value 0; row = `Y_BASE - sample`.
- `TRACE_COLOR`, 16'hFFE0: trace pixel colour.
- `BG_COLOR`, 16'h0000: background colour.
- `GRID_COLOR`, 16'h4208: graticule colour (only with `SCOPE_GRID_EN`).
- `clk_vga`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `adc_data`  in  8  ADC sample, unsigned.
- `adc_valid`  in  1  one-cycle strobe qualifying `adc_data`.
- `trig_level`  in  8  trigger threshold.
- `run`  in  1  capture enable.
- `force_trig`  in  1  one-cycle pulse that triggers immediately while ARMED.
- `hcount`  in  11  display x from the driver (0..799).
- `vcount`  in  11  display y from the driver (0..479).
- `tft_req`  in  1  driver pixel request.
- `tft_vs`  in  1  driver vsync, active-low.
- `data_in`  out  16  RGB565 pixel to the driver.
- `trig_state`  out  2  0 IDLE, 1 ARMED, 2 FILL, 3 DONE.
- `frame_swap`  out  1  one-cycle pulse on a bank swap.

## Operation
- Memory: two banks of 800×8, not reset. Read is asynchronous (LUT RAM). Write is synchronous on `clk_vga`.
- Bank pointers after reset: `cap_bank=0`, `disp_bank=1`, `disp_valid=0`.
- Capture FSM:
  - IDLE: while `run=1`, move to ARMED.
  - ARMED: `prev_s` holds the last valid sample; it is reset to 8'hFF so no false trigger occurs on the first sample.
    - Trigger condition: an `adc_valid` cycle with `prev_s < trig_level` and `adc_data >= trig_level`, or `force_trig`.
    - On trigger, move to FILL.
    - A trigger sample is written at address 0; a `force_trig`-only cycle writes nothing. `wr_addr` is set to 1 or 0 accordingly.
    - `run=0` in ARMED returns to IDLE.
  - FILL: each `adc_valid` writes `cap_bank[wr_addr]` and increments `wr_addr`. After the write to address 799, move to DONE. `run` is ignored in FILL.
  - DONE: wait for the vsync falling edge. Edge detection uses `tft_vs` registered once; the edge is `vs_d=1, tft_vs=0`. On the edge:
    - swap `cap_bank`/`disp_bank`;
    - set `disp_valid=1`;
    - pulse `frame_swap`;
    - go to ARMED if `run=1`, else IDLE.
- `adc_valid` outside ARMED/FILL is ignored; `prev_s` updates only in ARMED.
- Render, combinational for `data_in`:
  - `cur = disp_bank[hcount]`; `y_cur = Y_BASE - cur` (11-bit, no wrap, since 367-255 ≥ 0).
  - `y_prev` = registered row of the previous column. It updates on every `tft_req` cycle. At `hcount==0`, `y_prev` is ignored and `y_cur` is used.
  - Trace hit: `tft_req && disp_valid && min(y_prev,y_cur) <= vcount <= max(y_prev,y_cur)`. This joins consecutive samples with vertical segments.
  - Pixel priority: trace, then grid, then background.
  - `tft_req=0` gives `BG_COLOR`; the driver masks it anyway.

## Timing
- `data_in` has zero-cycle latency from `hcount`/`vcount`/`tft_req`, and must settle within one `clk_vga` period.
- Reset values: `data_in=BG_COLOR`, `trig_state=0`, `frame_swap=0`, `wr_addr=0`, `y_prev=Y_BASE`.
- Trigger-to-FILL is one cycle. A write lands on the `adc_valid` edge.
- Last write to DONE is one cycle. Vsync edge to swap is one cycle after the registered edge, so 2 cycles after `tft_vs` falls.
- If the swap and a trigger land on the same cycle, the trigger is not evaluated; the FSM enters ARMED fresh.
- Reset mid-FILL: the FSM returns to IDLE, `disp_valid=0`, and partial data is discarded.
- The display bank is never written while displayed.

## Configuration
- `SCOPE_GRID_EN` defined: the pixel is `GRID_COLOR` when `hcount%50==0` or `vcount%48==0`, giving a 16×10 grid, lower priority than the trace.
- `SCOPE_GRID_EN` undefined: no grid logic; non-trace pixels are `BG_COLOR`.

## Test plan
- Reset, then `run=1`, then a ramp 0..255 on `adc_valid` every cycle with `trig_level=128` → FILL entered on sample 128, which is stored at address 0. DONE follows after 800 valids. The swap comes 2 cycles after `tft_vs` falls, with a one-cycle `frame_swap`.
- After a swap with all samples = 8'h80 → in every line, only `vcount==239` returns `TRACE_COLOR`. Other rows return `BG_COLOR`, or `GRID_COLOR` at multiples of 48 with the macro defined.
- Samples alternating 0/255 → at column `hcount=1`, every row 112..367 inclusive is `TRACE_COLOR`; row 111 and row 368 are not.
- Constant input 8'h10 with `trig_level=8'h80` → stays ARMED. A `force_trig` pulse → FILL with `wr_addr=0`, then DONE after 800 valids.
- Reset asserted mid-FILL at `wr_addr=400` → `trig_state=0`, `disp_valid=0`, and all pixels `BG_COLOR` until the next completed capture and swap.
- `run=0` while in FILL → capture completes and swaps, then the FSM goes to IDLE and ignores further trigger crossings.
